// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential signed divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

  // Width of the iteration counter, which has to hold BW-1.
  function automatic int width_of(input int bw);
    return $clog2(bw);
  endfunction

endpackage

// File: rtl/rca_addsub.sv
// Combinational ripple-carry adder/subtractor: sum = a + b, or a - b as a + ~b + 1.
module rca_addsub #(
  parameter int W = 9
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] sum
);

  // NOTE: inside always_comb, blocking '=' is correct; the carry is read back
  // within the same pass, so each stage must see the previous stage's value.
  always_comb begin
    logic         carry;
    logic [W-1:0] bx;
    bx    = b ^ {W{sub}};
    carry = sub;
    sum   = '0;
    for (int i = 0; i < W; i++) begin
      sum[i] = a[i] ^ bx[i] ^ carry;
      carry  = (a[i] & bx[i]) | (carry & (a[i] ^ bx[i]));
    end
  end

endmodule

// File: rtl/seq_signed_divider.sv
// Sequential truncating signed divider: restoring division on magnitudes, one quotient bit per cycle.
module seq_signed_divider
  import div_pkg::*;
#(
  parameter int BW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [BW-1:0] dividend,
  input  logic [BW-1:0] divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [BW-1:0] quotient,
  output logic [BW-1:0] remainder,
  output logic          div_by_zero,
  output logic          overflow
);

  localparam int          CNT_W   = width_of(BW);
  localparam logic [BW-1:0] MIN_VAL = {1'b1, {(BW-1){1'b0}}};

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [BW-1:0]    a_q;       // dividend magnitude shifting out, quotient bits shifting in
  logic [BW-1:0]    dv_q;      // divisor magnitude
  logic [BW-1:0]    p_q;       // partial remainder; always < dv_q, so BW bits suffice
  logic [BW-1:0]    raw_q;     // raw dividend, returned as the remainder on divide-by-zero
  logic             sign_q_q, sign_r_q, dz_q, ov_q;

  logic [BW:0]      p_shift, trial;
  logic             ge;

  function automatic logic [BW-1:0] neg(input logic [BW-1:0] x);
    return ~x + BW'(1);
  endfunction

  // |MIN| wraps to MIN itself, which read as unsigned is exactly 2^(BW-1).
  function automatic logic [BW-1:0] mag(input logic [BW-1:0] x);
    return x[BW-1] ? neg(x) : x;
  endfunction

  assign p_shift = {p_q, a_q[BW-1]};

  rca_addsub #(.W(BW + 1)) u_trial (
    .a   (p_shift),
    .b   ({1'b0, dv_q}),
    .sub (1'b1),
    .sum (trial)
  );

  assign ge = ~trial[BW];

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);

  // NOTE: every sequential register uses non-blocking '<=' so all flops update
  // together from the values present before the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: state_d takes a default first, so no path through the case leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid)         state_d = CALC;
      CALC:    if (cnt_q == '0)      state_d = FIX;
      FIX:                           state_d = DONE;
      DONE:    if (out_ready)        state_d = IDLE;
      default:                       state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      a_q         <= '0;
      dv_q        <= '0;
      p_q         <= '0;
      raw_q       <= '0;
      sign_q_q    <= 1'b0;
      sign_r_q    <= 1'b0;
      dz_q        <= 1'b0;
      ov_q        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (in_valid) begin
          a_q      <= mag(dividend);
          dv_q     <= mag(divisor);
          p_q      <= '0;
          raw_q    <= dividend;
          sign_q_q <= dividend[BW-1] ^ divisor[BW-1];
          sign_r_q <= dividend[BW-1];
          dz_q     <= (divisor == '0);
          ov_q     <= (dividend == MIN_VAL) && (divisor == '1);
          cnt_q    <= CNT_W'(BW - 1);
        end
        CALC: begin
          a_q   <= {a_q[BW-2:0], ge};
          p_q   <= ge ? trial[BW-1:0] : p_shift[BW-1:0];
          cnt_q <= cnt_q - CNT_W'(1);
        end
        // Special cases ran the full CALC too, so latency does not depend on the operands.
        FIX: begin
          if (dz_q) begin
            quotient    <= '1;
            remainder   <= raw_q;
            div_by_zero <= 1'b1;
            overflow    <= 1'b0;
          end else if (ov_q) begin
            quotient    <= MIN_VAL;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b1;
          end else begin
            quotient    <= sign_q_q ? neg(a_q) : a_q;
            remainder   <= sign_r_q ? neg(p_q) : p_q;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_signed_divider.sv
// Directed bench for seq_signed_divider: BW=8 vectors, handshake and reset cases, plus a full BW=4 sweep.
module tb_seq_signed_divider;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // BW=8 instance
  logic       in_valid = 1'b0, out_ready = 1'b0;
  logic [7:0] dividend = '0, divisor = '0;
  logic       in_ready, out_valid, div_by_zero, overflow;
  logic [7:0] quotient, remainder;

  // BW=4 instance for the exhaustive sweep
  logic       in_valid4 = 1'b0, out_ready4 = 1'b0;
  logic [3:0] dividend4 = '0, divisor4 = '0;
  logic       in_ready4, out_valid4, div_by_zero4, overflow4;
  logic [3:0] quotient4, remainder4;

  int vectors    = 0;
  int miscompares = 0;

  seq_signed_divider #(.BW(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor),
    .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero), .overflow(overflow)
  );

  seq_signed_divider #(.BW(4)) dut4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid4), .in_ready(in_ready4),
    .dividend(dividend4), .divisor(divisor4),
    .out_valid(out_valid4), .out_ready(out_ready4),
    .quotient(quotient4), .remainder(remainder4),
    .div_by_zero(div_by_zero4), .overflow(overflow4)
  );

  typedef struct {
    logic [7:0] a, b, q, r;
    logic       dz, ov;
  } vec_t;

  // Operands are driven just after edge T and sampled at edge T+1; lat counts
  // edges after T until out_valid is seen. 0 means the wait timed out.
  task automatic do_op8(input logic [7:0] a, input logic [7:0] b, output int lat);
    lat = 0;
    @(posedge clk); #1;
    dividend = a; divisor = b; in_valid = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (k == 1) in_valid = 1'b0;
      if (out_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic accept8;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    #2;
    vectors++;
    if ({in_ready, out_valid, quotient, remainder, div_by_zero, overflow} !== {1'b1, 1'b0, 16'h0, 2'b00}) begin
      miscompares++;
      $display("FAIL reset: rdy=%b vld=%b q=%h r=%h dz=%b ov=%b, want rdy=1 vld=0 q=00 r=00 dz=0 ov=0",
               in_ready, out_valid, quotient, remainder, div_by_zero, overflow);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_vectors;
    vec_t tbl[12];
    int   lat;
    tbl = '{
      '{8'd100, 8'd7,   8'h0E, 8'h02, 1'b0, 1'b0},
      '{8'h9C,  8'd7,   8'hF2, 8'hFE, 1'b0, 1'b0},
      '{8'd100, 8'hF9,  8'hF2, 8'h02, 1'b0, 1'b0},
      '{8'h9C,  8'hF9,  8'h0E, 8'hFE, 1'b0, 1'b0},
      '{8'h80,  8'hFF,  8'h80, 8'h00, 1'b0, 1'b1},
      '{8'h80,  8'h01,  8'h80, 8'h00, 1'b0, 1'b0},
      '{8'd5,   8'h00,  8'hFF, 8'h05, 1'b1, 1'b0},
      '{8'h80,  8'h00,  8'hFF, 8'h80, 1'b1, 1'b0},
      '{8'hF9,  8'd2,   8'hFD, 8'hFF, 1'b0, 1'b0},
      '{8'h7F,  8'h80,  8'h00, 8'h7F, 1'b0, 1'b0},
      '{8'h80,  8'h80,  8'h01, 8'h00, 1'b0, 1'b0},
      '{8'h80,  8'd2,   8'hC0, 8'h00, 1'b0, 1'b0}
    };
    foreach (tbl[i]) begin
      do_op8(tbl[i].a, tbl[i].b, lat);
      vectors++;
      if (lat !== 10) begin
        miscompares++;
        $display("FAIL latency[%0d]: out_valid after %0d edges, want 10", i, lat);
      end
      vectors++;
      if ({quotient, remainder, div_by_zero, overflow} !== {tbl[i].q, tbl[i].r, tbl[i].dz, tbl[i].ov}) begin
        miscompares++;
        $display("FAIL result[%0d] %h/%h: q=%h r=%h dz=%b ov=%b, want q=%h r=%h dz=%b ov=%b",
                 i, tbl[i].a, tbl[i].b, quotient, remainder, div_by_zero, overflow,
                 tbl[i].q, tbl[i].r, tbl[i].dz, tbl[i].ov);
      end
      accept8;
      vectors++;
      if ({out_valid, in_ready, quotient, remainder} !== {1'b0, 1'b1, tbl[i].q, tbl[i].r}) begin
        miscompares++;
        $display("FAIL handshake[%0d]: vld=%b rdy=%b q=%h r=%h, want vld=0 rdy=1 q=%h r=%h",
                 i, out_valid, in_ready, quotient, remainder, tbl[i].q, tbl[i].r);
      end
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    do_op8(8'd100, 8'd7, lat);
    // Offer a new operation while the result is stalled; it must not be taken yet.
    dividend = 8'd3; divisor = 8'd1; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      vectors++;
      if ({out_valid, in_ready, quotient, remainder} !== {1'b1, 1'b0, 8'h0E, 8'h02}) begin
        miscompares++;
        $display("FAIL stall[%0d]: vld=%b rdy=%b q=%h r=%h, want vld=1 rdy=0 q=0e r=02",
                 i, out_valid, in_ready, quotient, remainder);
      end
    end
    accept8;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL release: rdy=%b, want 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL next_accept: rdy=%b, want 0", in_ready);
    end
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      if (out_valid) begin
        lat = k;
        break;
      end
      @(posedge clk); #1;
    end
    vectors++;
    if (lat == 0 || {quotient, remainder} !== {8'h03, 8'h00}) begin
      miscompares++;
      $display("FAIL next_result: seen=%0d q=%h r=%h, want q=03 r=00", lat, quotient, remainder);
    end
    accept8;
  endtask

  task automatic test_reset_mid_calc;
    int pulses = 0;
    int lat;
    @(posedge clk); #1;
    dividend = 8'd100; divisor = 8'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    vectors++;
    if ({out_valid, in_ready} !== 2'b01) begin
      miscompares++;
      $display("FAIL rst_async: vld=%b rdy=%b, want vld=0 rdy=1", out_valid, in_ready);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk); #1;
      if (out_valid) pulses++;
    end
    vectors++;
    if (pulses !== 0 || in_ready !== 1'b1 || {quotient, remainder} !== 16'h0) begin
      miscompares++;
      $display("FAIL rst_mid_calc: vld_cycles=%0d rdy=%b q=%h r=%h, want 0 1 00 00",
               pulses, in_ready, quotient, remainder);
    end
    do_op8(8'hF9, 8'd2, lat);
    vectors++;
    if (lat !== 10 || {quotient, remainder} !== {8'hFD, 8'hFF}) begin
      miscompares++;
      $display("FAIL after_rst: lat=%0d q=%h r=%h, want 10 fd ff", lat, quotient, remainder);
    end
    accept8;
  endtask

  task automatic test_sweep4;
    int bad = 0;
    for (int ai = -8; ai < 8; ai++) begin
      for (int bi = -8; bi < 8; bi++) begin
        int   q, r, lat;
        logic dz, ov;
        logic [3:0] eq, er;
        dz = 1'b0; ov = 1'b0;
        if (bi == 0) begin
          q = -1; r = ai; dz = 1'b1;
        end else if (ai == -8 && bi == -1) begin
          q = -8; r = 0; ov = 1'b1;
        end else begin
          q = ai / bi; r = ai % bi;
        end
        eq = 4'(q); er = 4'(r);
        @(posedge clk); #1;
        dividend4 = 4'(ai); divisor4 = 4'(bi); in_valid4 = 1'b1;
        lat = 0;
        for (int k = 1; k <= 30; k++) begin
          @(posedge clk); #1;
          if (k == 1) in_valid4 = 1'b0;
          if (out_valid4) begin
            lat = k;
            break;
          end
        end
        vectors++;
        if (lat !== 6 || {quotient4, remainder4, div_by_zero4, overflow4} !== {eq, er, dz, ov}) begin
          miscompares++;
          bad++;
          if (bad <= 10)
            $display("FAIL sweep4 %0d/%0d: lat=%0d q=%h r=%h dz=%b ov=%b, want lat=6 q=%h r=%h dz=%b ov=%b",
                     ai, bi, lat, quotient4, remainder4, div_by_zero4, overflow4, eq, er, dz, ov);
        end
        out_ready4 = 1'b1;
        @(posedge clk); #1;
        out_ready4 = 1'b0;
      end
    end
  endtask

  initial begin
    test_reset;
    test_vectors;
    test_back_to_back;
    test_reset_mid_calc;
    test_sweep4;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
